ifetch32_unit: RTL and testbench
================================

Name: ifetch32_unit

Overview:
Instruction fetch stage for the 32-bit MIPS datapath. Sits directly upstream of the decoder and register file.
- Owns the program counter and fetches words from an instruction memory over a req/ack handshake with wait states.
- Presents Instruction and opcplus4 (the JAL link value) to the decoder.
- Resolves next-PC from branch/jump controls fed back by control and execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 14, instruction memory word-address width
TIMEOUT_CYC, 255, max REQ cycles without imem_ack before fetch_err sets (0 = never time out)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  word address, = PC[ADDR_W+1:2]
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
hold  input  1  downstream stall; keep current instruction presented
Branch  input  1  beq: taken when Zero=1
nBranch  input  1  bne: taken when Zero=0
Zero  input  1  ALU zero flag
Jmp  input  1  j
Jal  input  1  jal
Jrn  input  1  jr
Add_result  input  32  branch target byte address from execute
Read_data_1  input  32  rs value for jr
Instruction  output  32  instruction presented to decoder
instr_valid  output  1  Instruction/opcplus4 valid this cycle
opcplus4  output  32  PC of presented instruction + 4
PC  output  32  address of presented/in-flight instruction
fetch_err  output  1  sticky imem timeout flag

Behaviour:
- Reset (rst=0 at clk edge): PC=RESET_PC, Instruction=0, opcplus4=RESET_PC+4, instr_valid=0, imem_req=0, fetch_err=0, timeout counter=0, state=IDLE. Reset has priority in every state and aborts any outstanding request; a late imem_ack after reset is ignored.
- FSM has three states: IDLE, REQ, PRESENT.
- IDLE: one cycle after reset release, then REQ.
- REQ:
  - imem_req=1, imem_addr from PC.
  - On imem_ack: register Instruction<=imem_rdata, opcplus4<=PC+4, go to PRESENT.
  - Otherwise increment the timeout counter.
  - Counter reaching TIMEOUT_CYC sets fetch_err. Stay in REQ; fetch_err clears only on reset.
- PRESENT:
  - instr_valid=1, imem_req=0.
  - Control inputs are sampled only here and describe the presented Instruction.
  - If hold=1: stay, all outputs stable.
  - If hold=0: load PC<=next_pc and go to REQ.
  - Minimum 3 cycles per instruction with zero-wait memory (REQ-ack, PRESENT, next REQ).
- next_pc priority, highest first:
  1. Jrn: Read_data_1.
  2. Jmp or Jal: {opcplus4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch & Zero) or (nBranch & ~Zero): Add_result.
  4. Otherwise: opcplus4.
- Width rules:
  - Bits [1:0] of next_pc are forced to 0.
  - PC+4 wraps modulo 2^32: 32'hFFFF_FFFC gives 0.
  - imem_addr truncates PC above bit ADDR_W+1.
- Simultaneous controls: resolved by the priority above. Branch and nBranch both set: taken if either condition holds.
- Delay slots: none. The redirect applies to the immediately next fetch.

Optional Feature:
Macro IFETCH_PERF_CNT_EN.
- Defined: adds outputs perf_instr (32) and perf_redirect (32).
  - perf_instr increments on each PRESENT->REQ transition.
  - perf_redirect increments when that transition takes a source other than opcplus4.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings IF_IDLE/IF_REQ/IF_PRESENT
  - the reset PC default
  - opcode constants OP_J=6'b000010, OP_JAL=6'b000011
- One natural sub-module: ifetch_nextpc, a combinational next-PC mux and priority resolver. The FSM, registers and counters stay in the top.

Test Plan:
1. Reset then zero-wait memory returning 32'h0043_3820 (add $7,$2,$3) -> imem_addr=0, instr_valid pulses with Instruction=32'h0043_3820 and opcplus4=4; next fetch at PC=4.
2. Present jal 0x40 (32'h0C00_0010) with Jal=1 at PC=8 -> opcplus4=32'h0000_000C held during PRESENT; next PC=32'h0000_0040.
3. beq with Branch=1, Zero=1, Add_result=32'h0000_0100 -> next PC=0x100. Repeat with Zero=0 -> next PC=PC+4. bne with nBranch=1, Zero=0 -> taken.
4. jr with Jrn=1, Jmp=1, Read_data_1=32'h0000_0203 -> next PC=32'h0000_0200 (Jrn wins, low bits cleared).
5. imem_ack delayed 3 cycles, then hold=1 for 4 cycles in PRESENT -> imem_req high 4 cycles, outputs stable through hold; TIMEOUT_CYC=2 with ack withheld -> fetch_err=1 until reset.
6. rst=0 asserted mid-REQ, then a stray imem_ack -> PC=RESET_PC, instr_valid=0, the ack is ignored, and the fetch restarts from IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 32-bit MIPS datapath: fetch FSM encoding,
// reset PC default, jump opcodes and a word-alignment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_REQ     = 2'd1,
    IF_PRESENT = 2'd2
  } if_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  // Instruction fetch only ever targets whole words.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_nextpc.sv
// Combinational next-PC selector: jr > j/jal > taken branch > sequential.
// Also reports whether a non-sequential source was chosen.
module ifetch_nextpc
  import mips_pkg::*;
(
  input  logic        jrn,
  input  logic        jmp,
  input  logic        jal,
  input  logic        branch,
  input  logic        nbranch,
  input  logic        zero,
  input  logic [31:0] add_result,
  input  logic [31:0] read_data_1,
  input  logic [31:0] opcplus4,
  input  logic [25:0] instr_index,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic        br_taken;
  logic [31:0] raw_pc;

  // Branch and nBranch together simply OR their conditions.
  assign br_taken = (branch & zero) | (nbranch & ~zero);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    raw_pc   = opcplus4;
    redirect = 1'b0;
    if (jrn) begin
      raw_pc   = read_data_1;
      redirect = 1'b1;
    end else if (jmp || jal) begin
      raw_pc   = {opcplus4[31:28], instr_index, 2'b00};
      redirect = 1'b1;
    end else if (br_taken) begin
      raw_pc   = add_result;
      redirect = 1'b1;
    end
  end

  assign next_pc = word_align(raw_pc);

endmodule

// File: rtl/ifetch32_unit.sv
// Instruction fetch stage: PC, req/ack fetch FSM with timeout, next-PC resolve.
// Optional performance counters are enabled with `define IFETCH_PERF_CNT_EN.
module ifetch32_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              hold,
  input  logic              Branch,
  input  logic              nBranch,
  input  logic              Zero,
  input  logic              Jmp,
  input  logic              Jal,
  input  logic              Jrn,
  input  logic [31:0]       Add_result,
  input  logic [31:0]       Read_data_1,
  output logic [31:0]       Instruction,
  output logic              instr_valid,
  output logic [31:0]       opcplus4,
  output logic [31:0]       PC,
  output logic              fetch_err
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_instr,
  output logic [31:0]       perf_redirect
`endif
);

  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYC);

  if_state_t   state_q, state_d;
  logic [31:0] to_cnt;
  logic [31:0] next_pc;
  logic        redirect;
  logic        accept;
  logic        advance;

  assign accept  = (state_q == IF_REQ) && imem_ack;
  assign advance = (state_q == IF_PRESENT) && !hold;

  ifetch_nextpc u_nextpc (
    .jrn         (Jrn),
    .jmp         (Jmp),
    .jal         (Jal),
    .branch      (Branch),
    .nbranch     (nBranch),
    .zero        (Zero),
    .add_result  (Add_result),
    .read_data_1 (Read_data_1),
    .opcplus4    (opcplus4),
    .instr_index (Instruction[25:0]),
    .next_pc     (next_pc),
    .redirect    (redirect)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IF_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_IDLE:    state_d = IF_REQ;
      IF_REQ:     if (imem_ack) state_d = IF_PRESENT;
      IF_PRESENT: if (!hold) state_d = IF_REQ;
      default:    state_d = IF_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == IF_REQ);
    instr_valid = (state_q == IF_PRESENT);
  end

  assign imem_addr = PC[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      PC          <= RESET_PC;
      Instruction <= '0;
      opcplus4    <= RESET_PC + 32'd4;
    end else if (accept) begin
      Instruction <= imem_rdata;
      opcplus4    <= PC + 32'd4;
    end else if (advance) begin
      PC          <= next_pc;
    end
  end

  // Wait counter restarts per fetch and saturates; the error flag is sticky.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (state_q == IF_REQ) begin
      if (to_cnt != '1) to_cnt <= to_cnt + 32'd1;
      if ((TIMEOUT_LIM != '0) && (to_cnt + 32'd1 == TIMEOUT_LIM)) fetch_err <= 1'b1;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_instr    <= '0;
      perf_redirect <= '0;
    end else if (advance) begin
      perf_instr <= perf_instr + 32'd1;
      if (redirect) perf_redirect <= perf_redirect + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch32_unit.sv
// Directed, table-driven bench for ifetch32_unit: a chain of fetches whose
// expected PCs follow from hand-computed next-PC values, plus timeout/reset.
module tb_ifetch32_unit;

  localparam int          ADDR_W      = 14;
  localparam int unsigned TIMEOUT_CYC = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              hold;
  logic              Branch, nBranch, Zero, Jmp, Jal, Jrn;
  logic [31:0]       Add_result, Read_data_1;
  logic [31:0]       Instruction;
  logic              instr_valid;
  logic [31:0]       opcplus4;
  logic [31:0]       PC;
  logic              fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifetch32_unit #(
    .RESET_PC    (32'h0000_0000),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .hold        (hold),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Zero        (Zero),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jrn         (Jrn),
    .Add_result  (Add_result),
    .Read_data_1 (Read_data_1),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .opcplus4    (opcplus4),
    .PC          (PC),
    .fetch_err   (fetch_err)
  );

  typedef struct {
    string       name;
    logic [31:0] word;
    int          waits;
    int          holds;
    logic        br, nbr, zero, jmp, jal, jrn;
    logic [31:0] add_res;
    logic [31:0] rd1;
    logic [31:0] pc;
    logic [31:0] opc4;
    logic [31:0] nxt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] word, input int waits,
                              input int holds, input logic [5:0] ctl, input logic [31:0] add_res,
                              input logic [31:0] rd1, input logic [31:0] pc,
                              input logic [31:0] opc4, input logic [31:0] nxt);
    vec_t v;
    v.name = name; v.word = word; v.waits = waits; v.holds = holds;
    // ctl bit order: {br, nbr, zero, jmp, jal, jrn}
    {v.br, v.nbr, v.zero, v.jmp, v.jal, v.jrn} = ctl;
    v.add_res = add_res; v.rd1 = rd1; v.pc = pc; v.opc4 = opc4; v.nxt = nxt;
    return v;
  endfunction

  task automatic clear_ctl();
    {Branch, nBranch, Zero, Jmp, Jal, Jrn} = '0;
    Add_result  = '0;
    Read_data_1 = '0;
  endtask

  // One full fetch/present/advance cycle, starting at a negedge.
  task automatic run_vec(input vec_t v);
    int          n;
    int          req_cycles;
    logic [31:0] exp_addr;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({v.name, ".req_seen"}, {31'd0, imem_req}, 32'd1);
    exp_addr = {18'd0, v.pc[15:2]};
    check({v.name, ".imem_addr"}, {18'd0, imem_addr}, exp_addr);
    check({v.name, ".pc_req"}, PC, v.pc);
    req_cycles = 1;
    for (int w = 0; w < v.waits; w++) begin
      @(negedge clk);
      if (imem_req) req_cycles++;
    end
    check({v.name, ".req_cycles"}, 32'(req_cycles), 32'(v.waits + 1));
    imem_ack   = 1'b1;
    imem_rdata = v.word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check({v.name, ".valid"}, {31'd0, instr_valid}, 32'd1);
    check({v.name, ".req_low"}, {31'd0, imem_req}, 32'd0);
    check({v.name, ".instr"}, Instruction, v.word);
    check({v.name, ".opcplus4"}, opcplus4, v.opc4);
    check({v.name, ".fetch_err"}, {31'd0, fetch_err}, 32'd0);
    {Branch, nBranch, Zero, Jmp, Jal, Jrn} = {v.br, v.nbr, v.zero, v.jmp, v.jal, v.jrn};
    Add_result  = v.add_res;
    Read_data_1 = v.rd1;
    hold = 1'b1;
    for (int h = 0; h < v.holds; h++) begin
      @(negedge clk);
      check({v.name, ".hold_valid"}, {31'd0, instr_valid}, 32'd1);
      check({v.name, ".hold_instr"}, Instruction, v.word);
      check({v.name, ".hold_opc4"}, opcplus4, v.opc4);
      check({v.name, ".hold_pc"}, PC, v.pc);
      check({v.name, ".hold_req"}, {31'd0, imem_req}, 32'd0);
    end
    hold = 1'b0;
    @(negedge clk);
    check({v.name, ".next_pc"}, PC, v.nxt);
    check({v.name, ".next_req"}, {31'd0, imem_req}, 32'd1);
    clear_ctl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 name         word          w  h  ctl        add_res       rd1           pc            opc4          nxt
    vecs[0]  = mk("add",       32'h0043_3820, 0, 0, 6'b000000, 32'h0,        32'h0,        32'h0000_0000, 32'h0000_0004, 32'h0000_0004);
    vecs[1]  = mk("nop",       32'h0000_0000, 1, 0, 6'b000000, 32'h0,        32'h0,        32'h0000_0004, 32'h0000_0008, 32'h0000_0008);
    vecs[2]  = mk("jal",       32'h0C00_0010, 0, 0, 6'b000010, 32'h0,        32'h0,        32'h0000_0008, 32'h0000_000C, 32'h0000_0040);
    vecs[3]  = mk("beq_t",     32'h1000_0010, 3, 4, 6'b101000, 32'h0000_0100, 32'h0,       32'h0000_0040, 32'h0000_0044, 32'h0000_0100);
    vecs[4]  = mk("beq_nt",    32'h1000_0010, 0, 0, 6'b100000, 32'h0000_0300, 32'h0,       32'h0000_0100, 32'h0000_0104, 32'h0000_0104);
    vecs[5]  = mk("bne_t",     32'h1400_0010, 2, 0, 6'b010000, 32'h0000_0200, 32'h0,       32'h0000_0104, 32'h0000_0108, 32'h0000_0200);
    vecs[6]  = mk("jr_jmp",    32'h0040_0008, 0, 0, 6'b000101, 32'h0,        32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 32'h0000_0200);
    vecs[7]  = mk("br_both",   32'h1000_0001, 0, 0, 6'b111000, 32'h0000_1003, 32'h0,       32'h0000_0200, 32'h0000_0204, 32'h0000_1000);
    vecs[8]  = mk("j_over_br", 32'h0800_0040, 0, 0, 6'b101100, 32'h0000_0008, 32'h0,       32'h0000_1000, 32'h0000_1004, 32'h0000_0100);
    vecs[9]  = mk("jr_hi",     32'h0040_0008, 0, 0, 6'b000001, 32'h0,        32'hF000_0010, 32'h0000_0100, 32'h0000_0104, 32'hF000_0010);
    vecs[10] = mk("j_region",  32'h0800_0040, 0, 0, 6'b000100, 32'h0,        32'h0,        32'hF000_0010, 32'hF000_0014, 32'hF000_0100);
    vecs[11] = mk("jr_top",    32'h0040_0008, 0, 0, 6'b000001, 32'h0,        32'hFFFF_FFFC, 32'hF000_0100, 32'hF000_0104, 32'hFFFF_FFFC);
    vecs[12] = mk("wrap_bne",  32'h1400_0010, 0, 1, 6'b011000, 32'h0000_0500, 32'h0,       32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000);

    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    hold       = 1'b0;
    clear_ctl();

    @(negedge clk);
    @(negedge clk);
    check("rst.pc", PC, 32'h0000_0000);
    check("rst.instr", Instruction, 32'h0);
    check("rst.opcplus4", opcplus4, 32'h0000_0004);
    check("rst.valid", {31'd0, instr_valid}, 32'd0);
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.fetch_err", {31'd0, fetch_err}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Ack withheld: error sets exactly when the wait count reaches the limit.
    for (int c = 0; c < int'(TIMEOUT_CYC) - 1; c++) @(negedge clk);
    check("to.below_limit", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    check("to.at_limit", {31'd0, fetch_err}, 32'd1);
    check("to.still_req", {31'd0, imem_req}, 32'd1);
    repeat (3) @(negedge clk);
    check("to.sticky", {31'd0, fetch_err}, 32'd1);

    // Reset mid-REQ with a stray ack around it.
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mid_rst.pc", PC, 32'h0000_0000);
    check("mid_rst.valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst.fetch_err", {31'd0, fetch_err}, 32'd0);
    check("mid_rst.req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("stray_ack.instr", Instruction, 32'h0);
    check("stray_ack.valid", {31'd0, instr_valid}, 32'd0);
    check("stray_ack.req", {31'd0, imem_req}, 32'd1);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
